// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_QDEPTH = 2;

  // A fetch address is usable only when word aligned and inside the memory.
  function automatic logic fetch_addr_ok(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry flushable FIFO of fetched {pc, instr} pairs; entry0 is always the head.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop_i & (count_q != 2'd0);
  assign push_ok = push_i & ((count_q < 2'(FETCH_QDEPTH)) | pop_ok);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) entry0_d = push_entry_i;
          else                 entry1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        // Simultaneous push/pop keeps the count; a full queue shifts the tail forward.
        2'b11: begin
          if (count_q == 2'd2) begin
            entry0_d = entry1_q;
            entry1_d = push_entry_i;
          end else begin
            entry0_d = push_entry_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : entry0_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the imem read port and feeds
// decode from a two-entry queue, with stall, redirect and fetch-fault handling.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic        ValidOut,
  input  logic        ReadyIn,
  output logic [31:0] PcOut,
  output logic [31:0] InstrOut,
  output logic        Fault
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         fault_q;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [1:0]   q_count;
  logic         q_empty;
  logic         in_range;
  logic         redirect_ok;
  logic         pop;
  logic         push;

  assign in_range    = fetch_addr_ok(pc_q, IMEM_WORDS);
  assign redirect_ok = fetch_addr_ok(RedirectPc, IMEM_WORDS);

  // Redirect outranks everything, including a pending handshake.
  assign pop  = ValidOut & ReadyIn & ~Stall & ~Redirect;
  assign push = (state_q == RUN) & ~Redirect & ~Stall & in_range &
                ((q_count < 2'(FETCH_QDEPTH)) | pop);

  assign push_entry = '{pc: pc_q, instr: ImemData};

  fetch_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (Redirect),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (q_count),
    .empty_o      (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (Redirect) begin
      pc_q    <= RedirectPc;
      state_q <= redirect_ok ? RUN : HALT;
      fault_q <= ~redirect_ok;
    end else if (!Stall) begin
      case (state_q)
        RUN: begin
          if (!in_range) begin
            state_q <= HALT;
            fault_q <= 1'b1;
          end else if (push) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        HALT:    pc_q <= pc_q;
        default: state_q <= HALT;
      endcase
    end
  end

  assign ImemAddr = pc_q;
  assign ValidOut = ~q_empty;
  assign PcOut    = head.pc;
  assign InstrOut = head.instr;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized and directed bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        ValidOut;
  logic        ReadyIn;
  logic [31:0] PcOut;
  logic [31:0] InstrOut;
  logic        Fault;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ImemAddr   (ImemAddr),
    .ImemData   (ImemData),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .ValidOut   (ValidOut),
    .ReadyIn    (ReadyIn),
    .PcOut      (PcOut),
    .InstrOut   (InstrOut),
    .Fault      (Fault)
  );

  // Instruction memory: word i holds 0x1000_0000 + i; poison outside the memory.
  assign ImemData = (ImemAddr < 32'h0000_0100) ? (32'h1000_0000 + (ImemAddr >> 2)) : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_fault;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h0000_0100);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0000_0000;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    ent_t e;
    if (rd) begin
      mq.delete();
      m_pc    = rpc;
      m_halt  = !addr_ok(rpc);
      m_fault = m_halt;
    end else if (!st) begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!m_halt) begin
        if (!addr_ok(m_pc)) begin
          m_halt  = 1'b1;
          m_fault = 1'b1;
        end else if (mq.size() < 2) begin
          e.pc    = m_pc;
          e.instr = mem_word(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid",    {31'd0, ValidOut}, {31'd0, mq.size() > 0});
    check("pc_out",   PcOut,    (mq.size() > 0) ? mq[0].pc : 32'h0);
    check("instr",    InstrOut, (mq.size() > 0) ? mq[0].instr : 32'h0);
    check("imemaddr", ImemAddr, m_pc);
    check("fault",    {31'd0, Fault}, {31'd0, m_fault});
  endtask

  // One clock: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    Stall      = st;
    Redirect   = rd;
    RedirectPc = rpc;
    ReadyIn    = rdy;
    model_step(st, rd, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [31:0] rpc;
    int          r;
    rst_n      = 1'b0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPc = 32'h0;
    ReadyIn    = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    check_outputs();

    // Streaming with decode always ready.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure from reset: queue fills, PC holds at 8.
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("hold_pc8", ImemAddr, 32'h0000_0008);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while full with a same-cycle handshake offered.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0020, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_head", PcOut, 32'h0000_0020);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Run off the end of memory, then recover with a redirect to 0.
    cycle(1'b0, 1'b1, 32'h0000_00F0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect halts with a fault.
    cycle(1'b0, 1'b1, 32'h0000_0022, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall and redirect together: redirect wins; then stalls alone freeze everything.
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-cycle.
    Stall = 1'b0; Redirect = 1'b0; ReadyIn = 1'b1;
    model_step(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      rpc = 32'($urandom_range(0, 70)) << 2;
      else if (r == 1) rpc = 32'($urandom_range(0, 280));
      else             rpc = 32'($urandom_range(0, 63)) << 2;
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer that owns the program counter and drives the combinational instruction memory read port (byte address in, 32-bit word out, same cycle). It issues sequential word fetches, buffers up to two fetched instructions in a flushable queue, and hands them to decode over a valid/ready handshake. It also handles stall, branch/jump redirect and out-of-range/misaligned fetch faults. The controller sits between the PC-update logic of the pipeline and the instruction memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_WORDS`, default 64: instruction memory depth in 32-bit words; a fetch at word index ≥ IMEM_WORDS is out of range.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ImemAddr`  out  32: byte address to instruction memory; equals the PC register.
- `ImemData`  in  32: instruction word returned combinationally for ImemAddr.
- `Stall`  in  1: freeze; blocks push, pop and PC advance.
- `Redirect`  in  1: load RedirectPc and flush the queue.
- `RedirectPc`  in  32: redirect target (byte address).
- `ValidOut`  out  1: queue head is valid.
- `ReadyIn`  in  1: decode accepts the head this cycle.
- `PcOut`  out  32: byte address of the head instruction; 0 when empty.
- `InstrOut`  out  32: head instruction; 0 when empty.
- `Fault`  out  1: sticky fetch fault; set while in HALT.

## Operation
- States: RUN, HALT. Reset state is RUN.
- in_range = (PC[31:2] < IMEM_WORDS) and PC[1:0] == 0.
- pop = ValidOut & ReadyIn & ~Stall & ~Redirect.
- push = RUN & ~Redirect & ~Stall & in_range & (count < 2 | pop). On push, enqueue {PC, ImemData} and set PC ← PC + 4 (32-bit wrap).
- RUN with ~in_range (and no Redirect or Stall): no push; go to HALT and set Fault. Queued entries keep draining normally.
- Redirect has the highest priority, above Stall:
  - Flush the queue (count ← 0).
  - Discard any handshake in the same cycle; the head is not consumed.
  - If RedirectPc is aligned and in range: PC ← RedirectPc, state ← RUN, Fault ← 0. This applies from either state.
  - Otherwise: PC ← RedirectPc, state ← HALT, Fault ← 1.
- HALT: no pushes. The PC holds. Only Redirect or reset leaves HALT.
- Queue: 2-entry FIFO. Push and pop in the same cycle are legal at any count, including full (count stays 2). Order is strictly preserved.
- Stall alone: PC, queue and state hold. ValidOut and the head outputs stay stable.

## Timing
- Reset values: PC = ImemAddr = RESET_PC, count = 0, ValidOut = 0, PcOut = 0, InstrOut = 0, Fault = 0, state = RUN.
- ValidOut, PcOut and InstrOut come from registered queue state only. There is no combinational path from ImemData, ReadyIn, Stall or Redirect to them.
- Latency:
  - First rising edge after rst_n deasserts pushes RESET_PC; ValidOut = 1 in the following cycle.
  - Redirect asserted in cycle N: ValidOut = 0 in N+1 (PC = target), target instruction at the head in N+2 (2-cycle bubble).
- Throughput: one instruction per cycle while ReadyIn = 1 and there is no stall or redirect.
- Backpressure: with ReadyIn = 0 the queue fills to 2, then push stops and the PC holds. The PC never runs ahead of the queue by more than the 2 entries.
- Asserting rst_n mid-operation immediately clears the queue, the PC and Fault, regardless of the clock.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {RUN, HALT}.
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
  - Localparam `FETCH_QDEPTH = 2`.
- Sub-module `fetch_queue`: 2-entry FIFO of fetch_entry_t with push, pop and flush. Flush overrides push and pop. Outputs are head entry, `count` and `empty`; it uses the same clk/rst_n.
- The top level holds the PC register, the FSM and the push/pop/redirect priority logic.

## Test plan
- Reset, RESET_PC = 0, memory word i = 32'h1000_0000 + i, ReadyIn = 1 → ValidOut rises in the 2nd cycle after reset release. The handshake stream is (0, 0x10000000), (4, 0x10000001), … with one per cycle.
- ReadyIn = 0 for 5 cycles after the first push → count stops at 2 and ImemAddr holds at 8. When ReadyIn rises, PCs 0, 4, 8, 12 are delivered with no loss or duplicate.
- Redirect to 0x20 while full with ReadyIn = 1 → the same-cycle handshake is ignored. The next cycle has ValidOut = 0; the cycle after has head PC 0x20 with instr 0x10000008.
- Sequential fetch reaching PC = 4·IMEM_WORDS = 0x100 → the two queued entries drain, Fault = 1, no further ValidOut. A Redirect to 0x0 clears Fault and resumes from PC 0.
- Redirect to 0x22 (misaligned) → queue flushed, Fault = 1, HALT, no pushes.
- Stall and Redirect asserted together, then rst_n pulsed low mid-stream:
  - Redirect wins.
  - Reset asynchronously returns every output to its reset value within the same cycle.
